// File: rtl/seq_shift_alu.sv
// Registered arithmetic/logic unit with serial shifter: arithmetic and logic ops complete in one cycle,
// shifts and rotates move one bit per cycle. Results are held behind valid/ready handshakes.
module seq_shift_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH + 1)'(1);
    localparam logic [SHW-1:0]   CNT_ONE = SHW'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt;
    logic             r_cout, w_cout_nxt;
    logic [SHW-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]       r_mode, w_mode_nxt;

    logic [WIDTH:0]   w_cin_x;
    logic [WIDTH:0]   w_arith;
    logic [WIDTH-1:0] w_step;
    logic             w_step_cout;

    assign w_cin_x = {{WIDTH{1'b0}}, cin};

    // Single-cycle result; bit WIDTH carries the carry-out.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_arith = '0;
        casez ({op[2:0], cin})
            4'b000?: w_arith = {1'b0, a} + {1'b0, b} + w_cin_x;
            4'b001?: w_arith = {1'b0, a} + {1'b0, ~b} + w_cin_x;
            4'b0100: w_arith = {1'b0, ~a + ONE};
            4'b0101: w_arith = {1'b0, a} + ONE_X;
            4'b0110: w_arith = {1'b0, b} + {1'b0, ~ONE} + ONE_X;
            4'b0111: w_arith = {1'b0, a};
            4'b100?: w_arith = {1'b0, a & b};
            4'b101?: w_arith = {1'b0, a | b};
            4'b110?: w_arith = {1'b0, ~a};
            4'b111?: w_arith = {1'b0, a ^ b};
            default: w_arith = '0;
        endcase
    end

    always_comb begin
        w_step      = r_work;
        w_step_cout = 1'b0;
        case (r_mode)
            2'b00: begin
                w_step      = {1'b0, r_work[WIDTH-1:1]};
                w_step_cout = r_work[0];
            end
            2'b01: begin
                w_step      = {r_work[WIDTH-2:0], 1'b0};
                w_step_cout = r_work[WIDTH-1];
            end
            2'b10: begin
                w_step      = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                w_step_cout = r_work[WIDTH-1];
            end
            default: begin
                w_step      = {r_work[0], r_work[WIDTH-1:1]};
                w_step_cout = r_work[0];
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cout_nxt  = r_cout;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (!op[3]) begin
                        w_work_nxt  = w_arith[WIDTH-1:0];
                        w_cout_nxt  = w_arith[WIDTH];
                        w_state_nxt = DONE;
                    end else begin
                        w_work_nxt  = a;
                        w_cout_nxt  = 1'b0;
                        w_mode_nxt  = op[1:0];
                        w_cnt_nxt   = shamt;
                        w_state_nxt = (shamt == '0) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_work_nxt = w_step;
                w_cout_nxt = w_step_cout;
                w_cnt_nxt  = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cout  <= w_cout_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_work;
    assign cout      = r_cout;
    assign zero      = out_valid && (r_work == '0);

endmodule

// File: tb/tb_seq_shift_alu.sv
// Directed bench for seq_shift_alu (WIDTH=8): vector table for single operations plus
// hand-written back-pressure and mid-shift reset sequences.
module tb_seq_shift_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       zero;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_shift_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] shamt;
        logic [7:0] res;
        logic       co;
        int         lat;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the result, check it, then drain it.
    task automatic run_op(input string tag, input logic [3:0] t_op, input logic t_cin,
                          input logic [7:0] t_a, input logic [7:0] t_b, input logic [2:0] t_sh,
                          input logic [7:0] e_res, input logic e_co, input int e_lat);
        int n;
        bit done;
        @(negedge clk);
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = t_op;
        cin      = t_cin;
        a        = t_a;
        b        = t_b;
        shamt    = t_sh;
        @(posedge clk);
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                op       = ~t_op;
                cin      = ~t_cin;
                a        = ~t_a;
                b        = 8'h5A;
                shamt    = ~t_sh;
            end
            if (out_valid) done = 1'b1;
            else check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
        end
        check({tag, " latency"}, 32'(n), 32'(e_lat));
        check({tag, " result"}, 32'(result), 32'(e_res));
        check({tag, " cout"}, 32'(cout), 32'(e_co));
        check({tag, " zero"}, 32'(zero), 32'(e_res == 8'h00));
        check({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drained"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        //          op       cin   a      b      sh    res    co    lat
        vecs[0]  = '{4'b0000, 1'b1, 8'hFF, 8'h00, 3'd0, 8'h00, 1'b1, 1};
        vecs[1]  = '{4'b0001, 1'b1, 8'h05, 8'h07, 3'd0, 8'hFE, 1'b0, 1};
        vecs[2]  = '{4'b0011, 1'b0, 8'h00, 8'h00, 3'd0, 8'hFF, 1'b0, 1};
        vecs[3]  = '{4'b0011, 1'b0, 8'h55, 8'h10, 3'd0, 8'h0F, 1'b1, 1};
        vecs[4]  = '{4'b0001, 1'b1, 8'h07, 8'h05, 3'd0, 8'h02, 1'b1, 1};
        vecs[5]  = '{4'b0010, 1'b0, 8'h01, 8'h33, 3'd0, 8'hFF, 1'b0, 1};
        vecs[6]  = '{4'b0010, 1'b0, 8'h00, 8'h33, 3'd0, 8'h00, 1'b0, 1};
        vecs[7]  = '{4'b0010, 1'b1, 8'hFF, 8'h33, 3'd0, 8'h00, 1'b1, 1};
        vecs[8]  = '{4'b0011, 1'b1, 8'hA5, 8'h33, 3'd0, 8'hA5, 1'b0, 1};
        vecs[9]  = '{4'b0100, 1'b0, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1};
        vecs[10] = '{4'b0101, 1'b1, 8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 1};
        vecs[11] = '{4'b0110, 1'b0, 8'h5A, 8'h00, 3'd0, 8'hA5, 1'b0, 1};
        vecs[12] = '{4'b0111, 1'b1, 8'hFF, 8'hFF, 3'd0, 8'h00, 1'b0, 1};
        vecs[13] = '{4'b1010, 1'b0, 8'h81, 8'h00, 3'd3, 8'h0C, 1'b0, 4};
        vecs[14] = '{4'b1000, 1'b0, 8'h0B, 8'h00, 3'd2, 8'h02, 1'b1, 3};
        vecs[15] = '{4'b1001, 1'b0, 8'h0B, 8'h00, 3'd0, 8'h0B, 1'b0, 1};
        vecs[16] = '{4'b1011, 1'b0, 8'h01, 8'h00, 3'd1, 8'h80, 1'b1, 2};
        vecs[17] = '{4'b1001, 1'b0, 8'h81, 8'h00, 3'd7, 8'h80, 1'b0, 8};
        vecs[18] = '{4'b1111, 1'b0, 8'h02, 8'h00, 3'd2, 8'h80, 1'b1, 3};
        vecs[19] = '{4'b1100, 1'b0, 8'hC0, 8'h00, 3'd7, 8'h01, 1'b1, 8};
        vecs[20] = '{4'b1000, 1'b0, 8'h01, 8'h00, 3'd1, 8'h00, 1'b1, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        cin       = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        shamt     = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset zero", 32'(zero), 32'd0);

        for (int i = 0; i < 21; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b,
                   vecs[i].shamt, vecs[i].res, vecs[i].co, vecs[i].lat);
        end

        // Back-pressure: result held for 5 cycles while a competing request is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'b0000;
        cin      = 1'b0;
        a        = 8'h12;
        b        = 8'h34;
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h01;
        check("bp first out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d result", i), 32'(result), 32'h46);
            check($sformatf("bp%0d cout", i), 32'(cout), 32'd0);
            check($sformatf("bp%0d zero", i), 32'(zero), 32'd0);
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp no phantom op", 32'(out_valid), 32'd0);

        // Reset in the middle of a 7-step shift, then a normal operation.
        in_valid = 1'b1;
        op       = 4'b1001;
        a        = 8'hFF;
        shamt    = 3'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-shift out_valid", 32'(out_valid), 32'd0);
        check("mid-shift in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort zero", 32'(zero), 32'd0);
        repeat (8) @(negedge clk);
        check("abort stays idle", 32'(out_valid), 32'd0);
        run_op("post_abort", 4'b0000, 1'b0, 8'h01, 8'h01, 3'd0, 8'h02, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
